tile_stream_tx: RTL and testbench

TILE_STREAM_TX -- requirements
Module: tile_stream_tx

---
 rtl/tile_stream_pkg.sv | 22 ++
 rtl/tile_frame_buf.sv | 24 ++
 rtl/tile_stream_tx.sv | 123 ++++++++++++
 tb/tb_tile_stream_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_stream_pkg.sv
// Shared definitions for the tile streaming path (frame geometry and TX FSM states).
// Also consumed by the downstream bias-add stage.
package tile_stream_pkg;
  localparam int TILE_SIZE  = 4;
  localparam int DATA_WIDTH = 16;
  localparam int D          = 256;
  localparam int TILE_DEPTH = D / TILE_SIZE;
  localparam int ADDR_W     = $clog2(TILE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_SEND,
    S_GAP,
    S_DRAIN
  } tx_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tile_frame_buf.sv
// Register-based frame buffer: one synchronous write port, one asynchronous read port.
// No reset on the storage; contents are undefined until written.
module tile_frame_buf
  import tile_stream_pkg::*;
#(
  parameter int DEPTH = TILE_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int W     = TILE_SIZE * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/tile_stream_tx.sv
// Streams one stored frame as TILE_DEPTH beats with an SOF marker, a minimum idle gap
// between beats and a cap on beats awaiting downstream ack.
module tile_stream_tx #(
  parameter int TILE_SIZE    = tile_stream_pkg::TILE_SIZE,
  parameter int DATA_WIDTH   = tile_stream_pkg::DATA_WIDTH,
  parameter int D            = tile_stream_pkg::D,
  parameter int TILE_DEPTH   = D / TILE_SIZE,
  parameter int ADDR_W       = $clog2(TILE_DEPTH),
  parameter int GAP          = 2,
  parameter int MAX_INFLIGHT = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       wr_en,
  input  logic [ADDR_W-1:0]                          wr_addr,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]            wr_data,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       sof,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] out_vec,
  input  logic                                       ack
);
  import tile_stream_pkg::*;

  localparam int BW = TILE_SIZE * DATA_WIDTH;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int GW = cnt_width(GAP);
  localparam logic [ADDR_W-1:0] LAST_BEAT    = ADDR_W'(TILE_DEPTH - 1);
  localparam logic [GW-1:0]     GAP_LOAD     = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0]     INFLIGHT_CAP = IW'(MAX_INFLIGHT);

  tx_state_t         state;
  logic [ADDR_W-1:0] beat_idx;
  logic [GW-1:0]     gap_cnt;
  logic [IW-1:0]     inflight;
  logic [BW-1:0]     rd_data;
  logic              fire;

  // Handshake: a beat transfers on a cycle with out_valid && out_ready; once raised,
  // out_valid and out_vec hold until that transfer because inflight can only fall meanwhile.
  tile_frame_buf #(
    .DEPTH (TILE_DEPTH),
    .AW    (ADDR_W),
    .W     (BW)
  ) u_frame_buf (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (beat_idx),
    .rd_data (rd_data)
  );

  assign out_valid = (state == S_SEND) && (inflight < INFLIGHT_CAP);
  assign fire      = out_valid && out_ready;
  assign out_vec   = rd_data;

  // An ack in the same cycle as a fire completes that beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (fire && !ack) begin
      inflight <= inflight + IW'(1);
    end else if (!fire && ack && (inflight != '0)) begin
      inflight <= inflight - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat_idx <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sof      <= 1'b0;
    end else begin
      done <= 1'b0;
      sof  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SOF;
            beat_idx <= '0;
            busy     <= 1'b1;
            sof      <= 1'b1;
          end
        end
        S_SOF: state <= S_SEND;
        S_SEND: begin
          if (fire) begin
            if (beat_idx == LAST_BEAT) begin
              state <= S_DRAIN;
            end else begin
              beat_idx <= beat_idx + ADDR_W'(1);
              if (GAP == 0) begin
                state <= S_SEND;
              end else begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_SEND;
          else gap_cnt <= gap_cnt - GW'(1);
        end
        S_DRAIN: begin
          if (inflight == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_stream_tx.sv
// Bench for tile_stream_tx: frames are predicted from a shadow copy of the buffer and
// checked beat by beat by a monitor draining an expected queue.
module tb_tile_stream_tx;
  import tile_stream_pkg::*;

  localparam int TS    = TILE_SIZE;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = TILE_DEPTH;
  localparam int AW    = ADDR_W;
  localparam int BW    = TS * DW;
  localparam int GAP_C = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BW-1:0] wr_data = '0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic ack = 1'b0;
  logic busy, done, sof, out_valid;
  logic signed [TS-1:0][DW-1:0] out_vec;

  tile_stream_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sof       (sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .ack       (ack)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] model_mem[DEPTH];
  int ack_sched[$];
  int model_inflight = 0;
  int fire_cnt = 0, sof_cnt = 0, done_cnt = 0;
  int sof_cyc = -1, first_valid_cyc = -1, last_fire = 0;
  int exp_interval = 0;
  bit prev_stall = 0;

  // stimulus knobs
  int ack_mode = 0;  // 0 fixed delay, 1 random delay, 2 same cycle as fire
  int ack_delay = 3;
  bit ready_rand = 0, stall_en = 0, force_ack = 0;
  int stall_left = 5, stall_seen = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (sof) begin
        sof_cnt++;
        sof_cyc = cyc;
        check("sof_without_beat", out_valid, 0);
      end
      if (done) done_cnt++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) check("valid_held_until_fire", out_valid, 1);
      if (out_valid) begin
        check("inflight_cap", model_inflight, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", out_vec);
        end else begin
          check("beat_data", out_vec, exp_q[0]);
        end
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (fire_cnt > 0) begin
            check("beat_spacing_min", ((cyc - last_fire) >= GAP_C + 1), 1);
            if (exp_interval > 0) check("beat_spacing", cyc - last_fire, exp_interval);
          end
          last_fire = cyc;
          fire_cnt++;
          if (ack_mode == 0) ack_sched.push_back(cyc + ack_delay);
          else if (ack_mode == 1) ack_sched.push_back(cyc + int'($urandom_range(1, 10)));
        end
      end
      prev_stall = out_valid && !out_ready;
      if (out_valid && out_ready && !ack) model_inflight++;
      else if (!(out_valid && out_ready) && ack && model_inflight > 0) model_inflight--;
    end else begin
      model_inflight = 0;
      prev_stall = 0;
    end
  end

  // downstream driver: ready and ack
  always @(posedge clk) begin
    #1;
    if (!stall_en) begin
      stall_left = 5;
      stall_seen = 0;
    end
    if (!rst_n) ack_sched.delete();
    if (stall_en && fire_cnt == 7 && out_valid && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
      stall_seen++;
    end else if (ready_rand) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
    ack = 1'b0;
    if (force_ack) begin
      ack = 1'b1;
    end else if (ack_mode == 2) begin
      ack = out_valid && out_ready;
    end else if (ack_sched.size() > 0 && ack_sched[0] <= cyc) begin
      ack = 1'b1;
      void'(ack_sched.pop_front());
    end
  end

  // driver tasks
  task automatic load_buffer(input bit random_data);
    for (int k = 0; k < DEPTH; k++) begin
      if (random_data) model_mem[k] = {$urandom, $urandom};
      else model_mem[k] = {DW'(4 * k + 3), DW'(4 * k + 2), DW'(4 * k + 1), DW'(4 * k)};
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      wr_addr = AW'(k);
      wr_data = model_mem[k];
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input bit interfere, input int reset_at);
    int t0;
    bit aborted = 0;
    bit interfered = 0;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(model_mem[k]);
    fire_cnt = 0;
    sof_cnt = 0;
    done_cnt = 0;
    sof_cyc = -1;
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("busy_before_start", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 3000 && done_cnt == 0 && !aborted; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (interfere && !interfered && fire_cnt == 20) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = AW'(5);
        wr_data = {$urandom, $urandom};
        interfered = 1;
      end
      if (reset_at >= 0 && fire_cnt == reset_at) begin
        rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sof", sof, 0);
        check("rst_out_valid", out_valid, 0);
        aborted = 1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    if (aborted) return;
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no done expected done within 3000 cycles");
      return;
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_count", done_cnt, 1);
    check("sof_count", sof_cnt, 1);
    check("beat_count", fire_cnt, DEPTH);
    check("beats_left", exp_q.size(), 0);
    check("sof_latency", sof_cyc - t0, 1);
    check("first_valid_latency", first_valid_cyc - t0, 2);
  endtask

  // main sequence
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sof", sof, 0);
    check("reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ramp frame, ack three cycles after each beat
    load_buffer(0);
    ack_mode = 0;
    ack_delay = 3;
    exp_interval = 4;
    run_frame(0, -1);

    // downstream stall on beat 7
    stall_en = 1;
    exp_interval = 0;
    run_frame(0, -1);
    check("stall_cycles", stall_seen, 5);
    stall_en = 0;

    // random data, random ready, ack delays up to 10 cycles
    load_buffer(1);
    ack_mode = 1;
    ready_rand = 1;
    run_frame(0, -1);

    // start and write while busy are dropped; next frame still sees old entry 5
    ack_mode = 0;
    ready_rand = 0;
    exp_interval = 4;
    run_frame(1, -1);
    run_frame(0, -1);

    // reset mid-frame, then a fresh frame from beat 0
    run_frame(0, 30);
    run_frame(0, -1);

    // spurious ack while idle, then acks coinciding with each beat
    @(posedge clk);
    #1;
    force_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 0;
    ack_mode = 2;
    exp_interval = GAP_C + 1;
    run_frame(0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
